// File: rtl/render_pkg.sv
// Shared widths and FSM state type for the render stream blocks.
package render_pkg;

  localparam int unsigned X_W     = 11;
  localparam int unsigned Y_W     = 12;
  localparam int unsigned COLOR_W = 8;

  typedef enum logic [0:0] {
    StIdle,
    StScan
  } scan_state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position counter: advances on en, wraps at line and frame ends,
// and flags the last column and the last pixel of the frame.
module raster_counter
  import render_pkg::*;
#(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           x_last,
  output logic           frame_last
);

  logic y_last;

  always_comb begin
    x_last     = (x == X_W'(H_RES - 1));
    y_last     = (y == Y_W'(V_RES - 1));
    frame_last = x_last && y_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_stream_source.sv
// Raster-order pixel stream source with stall, continuous mode and registered outputs.
// Define PIXEL_STREAM_TEST_PATTERN_EN for an x/y test pattern instead of BG_COLOR.
module pixel_stream_source
  import render_pkg::*;
#(
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      continuous,
  input  logic                      stall,
  output logic signed [X_W-1:0]     x,
  output logic signed [Y_W-1:0]     y,
  output logic        [COLOR_W-1:0] r,
  output logic        [COLOR_W-1:0] g,
  output logic        [COLOR_W-1:0] b,
  output logic                      valid,
  output logic                      sof,
  output logic                      eol,
  output logic                      eof,
  output logic                      busy,
  output logic                      done
);

  scan_state_e          state_q;
  logic [X_W-1:0]       cnt_x;
  logic [Y_W-1:0]       cnt_y;
  logic                 cnt_x_last;
  logic                 cnt_frame_last;
  logic                 adv;
  logic                 finish;
  logic [COLOR_W-1:0]   pix_r, pix_g, pix_b;

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_raster_counter (
    .clk        (clk),
    .rst        (rst),
    .en         (adv),
    .x          (cnt_x),
    .y          (cnt_y),
    .x_last     (cnt_x_last),
    .frame_last (cnt_frame_last)
  );

  // eof marks the cycle in which continuous is sampled to decide wrap vs. stop.
  always_comb begin
    finish = (state_q == StScan) && eof && !continuous;
    adv    = ((state_q == StIdle) && start) ||
             ((state_q == StScan) && !finish && !stall);
  end

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
  always_comb begin
    pix_r = cnt_x[COLOR_W-1:0];
    pix_g = cnt_y[COLOR_W-1:0];
    pix_b = cnt_x[COLOR_W-1:0] ^ cnt_y[COLOR_W-1:0];
  end
`else
  always_comb begin
    pix_r = BG_COLOR[23:16];
    pix_g = BG_COLOR[15:8];
    pix_b = BG_COLOR[7:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x       <= '0;
      y       <= '0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
      valid   <= 1'b0;
      sof     <= 1'b0;
      eol     <= 1'b0;
      eof     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      valid <= 1'b0;
      sof   <= 1'b0;
      eol   <= 1'b0;
      eof   <= 1'b0;
      done  <= 1'b0;
      if (adv) begin
        state_q <= StScan;
        busy    <= 1'b1;
        valid   <= 1'b1;
        x       <= cnt_x;
        y       <= cnt_y;
        r       <= pix_r;
        g       <= pix_g;
        b       <= pix_b;
        sof     <= (cnt_x == '0) && (cnt_y == '0);
        eol     <= cnt_x_last;
        eof     <= cnt_frame_last;
      end else if (finish) begin
        state_q <= StIdle;
        busy    <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pixel_stream_source.md
PIXEL_STREAM_SOURCE -- requirements
Module: pixel_stream_source

Interface
REQ-001 Parameter H_RES, default 640, pixels per line (range 1..1023).
REQ-002 Parameter V_RES, default 480, lines per frame (range 1..2047).
REQ-003 Parameter BG_COLOR, default 24'h000000, background colour {r,g,b} driven on every pixel.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a frame scan.
REQ-007 continuous  in  1  1 = restart the next frame automatically after the last pixel.
REQ-008 stall  in  1  1 = hold the scan position and emit no pixel this cycle.
REQ-009 x  out  11 signed  pixel column.
REQ-010 y  out  12 signed  pixel row.
REQ-011 r, g, b  out  8 each  pixel colour.
REQ-012 valid  out  1  x/y/r/g/b carry a pixel this cycle.
REQ-013 sof, eol, eof  out  1 each  first pixel of frame, last pixel of line, last pixel of frame; qualified by valid.
REQ-014 busy  out  1  scan in progress.
REQ-015 done  out  1  one-cycle pulse after the last pixel of a non-continuous scan.

Function
REQ-016 The block SHALL be the stream source for the renderer chain: it emits raster-order pixels x=0..H_RES-1 within y=0..V_RES-1, one per non-stalled cycle.
REQ-017 The FSM SHALL have states IDLE and SCAN; IDLE->SCAN on start=1; SCAN->IDLE after the final pixel when continuous=0.
REQ-018 All outputs SHALL be registered; the first pixel (0,0) with valid=1 and sof=1 SHALL appear in the cycle after start is sampled in IDLE.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 When stall=1 in SCAN, the next cycle SHALL have valid=0, sof/eol/eof=0, and the scan position SHALL not advance; x/y/r/g/b hold their last values.
REQ-021 x SHALL wrap to 0 and y SHALL increment after x=H_RES-1; eol=1 on that pixel.
REQ-022 eof SHALL equal 1 only on pixel (H_RES-1, V_RES-1), together with eol.
REQ-023 After eof with continuous=1 the next emitted pixel SHALL be (0,0) with sof=1, with no idle cycle; continuous is sampled on the eof cycle.
REQ-024 After eof with continuous=0, done SHALL pulse 1 cycle and busy SHALL fall in that same cycle; valid=0.
REQ-025 H_RES=1 and V_RES=1 SHALL give a single pixel with sof, eol and eof all set.
REQ-026 x and y SHALL never be negative; counter widths follow the shared package constants.

Reset
REQ-027 rst=1 SHALL force IDLE; x, y, r, g, b, valid, sof, eol, eof, busy and done all 0 on the next cycle.
REQ-028 rst asserted mid-frame SHALL abort the scan without a done pulse; a later start SHALL restart at (0,0).
REQ-029 rst SHALL take priority over start and stall in the same cycle.

Configuration
REQ-030 Macro PIXEL_STREAM_TEST_PATTERN_EN defined: r=x[7:0], g=y[7:0], b=x[7:0]^y[7:0] per pixel, BG_COLOR unused.
REQ-031 Macro undefined: r/g/b = BG_COLOR on every valid pixel; pattern logic not compiled in.

Structure
REQ-032 Shared package render_pkg SHALL hold X_W=11, Y_W=12, COLOR_W=8 and the FSM state typedef.
REQ-033 Sub-module raster_counter SHALL hold the x/y counters with enable, wrap and last-pixel flags; the FSM and output registers stay in pixel_stream_source.

Verification
REQ-034 H_RES=4, V_RES=3, start pulse, continuous=0 -> 12 valid pixels (0,0)..(3,2) in consecutive cycles; eol at x=3; eof at (3,2); done 1 cycle later.
REQ-035 Same frame, stall=1 for 2 cycles after pixel (1,0) -> 2 cycles valid=0, then (2,0); total 14 cycles from first pixel to done.
REQ-036 continuous=1, 2x2 frame -> after (1,1) eof, next cycle (0,0) sof=1, no gap; done never pulses.
REQ-037 rst during pixel (2,1) of 4x3 frame -> next cycle all outputs 0, busy=0, no done; new start -> (0,0) sof=1.
REQ-038 Test-pattern build, pixel (3,5) -> r=8'h03, g=8'h05, b=8'h06; default build with BG_COLOR=24'h102030 -> r=8'h10, g=8'h20, b=8'h30.
REQ-039 H_RES=1, V_RES=1 -> single valid pixel (0,0) with sof=eol=eof=1, done the next cycle.
